// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - register file dump sequencer: halts the pipeline, borrows the RS read port
// and streams every register MSB-first as bytes over a valid/ready interface.
module regfile_dump_ctrl #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dump_req,
  input  logic [NB_ADDR-1:0] i_pipe_rs_addr,
  input  logic [NB_REG-1:0]  i_rf_rs_data,
  output logic [NB_ADDR-1:0] o_rf_rs_addr,
  output logic               o_dunit_clk_en,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_BYTES = NB_REG / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_REG  = NB_ADDR'(N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ADDR,
    S_SEND,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NB_ADDR-1:0]   reg_cnt_q, reg_cnt_d;
  logic [NB_BCNT-1:0]   byte_cnt_q, byte_cnt_d;
  logic [NB_REG-1:0]    shift_q, shift_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NB_REG-1:0]    shift_nxt;

  assign shift_nxt = shift_q << 8;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      reg_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      reg_cnt_q  <= reg_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // tx_data_q mirrors the top byte of the shift register while sending and
  // keeps the last byte shown once the stream has moved on.
  always_comb begin
    state_d    = state_q;
    reg_cnt_d  = reg_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    o_tx_valid = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_dump_req) begin
          state_d    = S_HALT;
          reg_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      S_HALT: state_d = S_ADDR;
      S_ADDR: begin
        shift_d   = i_rf_rs_data;
        tx_data_d = i_rf_rs_data[NB_REG-1 -: 8];
        state_d   = S_SEND;
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready) begin
          if (byte_cnt_q != LAST_BYTE) begin
            shift_d    = shift_nxt;
            tx_data_d  = shift_nxt[NB_REG-1 -: 8];
            byte_cnt_d = byte_cnt_q + NB_BCNT'(1);
          end else if (reg_cnt_q != LAST_REG) begin
            byte_cnt_d = '0;
            reg_cnt_d  = reg_cnt_q + NB_ADDR'(1);
            state_d    = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_tx_data      = tx_data_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_dunit_clk_en = (state_q == S_IDLE);
  assign o_rf_rs_addr   = (state_q == S_IDLE) ? i_pipe_rs_addr : reg_cnt_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - directed self-checking bench for regfile_dump_ctrl.
module tb_regfile_dump_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic        i_dump_req;
  logic [4:0]  i_pipe_rs_addr;
  logic [31:0] i_rf_rs_data;
  logic [4:0]  o_rf_rs_addr;
  logic        o_dunit_clk_en;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;

  logic [31:0] rf [32];
  logic [7:0]  log_q [$];
  logic [7:0]  exp_q [$];
  int          busy_cnt;
  int          done_cnt;
  int          clk_viol;
  int          checks;
  int          failures;

  regfile_dump_ctrl #(.NB_REG(32), .NB_ADDR(5), .N_REGS(32)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_dump_req     (i_dump_req),
    .i_pipe_rs_addr (i_pipe_rs_addr),
    .i_rf_rs_data   (i_rf_rs_data),
    .o_rf_rs_addr   (o_rf_rs_addr),
    .o_dunit_clk_en (o_dunit_clk_en),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  assign i_rf_rs_data = rf[o_rf_rs_addr];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_tx_valid && i_tx_ready) log_q.push_back(o_tx_data);
    if (o_busy) busy_cnt++;
    if (o_done) done_cnt++;
    if (o_busy && o_dunit_clk_en) clk_viol++;
  end

  task automatic clear_stats();
    log_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    clk_viol = 0;
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(rf[r][8*b +: 8]);
  endtask

  task automatic start_dump();
    @(posedge i_clk); #1 i_dump_req = 1'b1;
    @(posedge i_clk); #1 i_dump_req = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_dump_req = 1'b0; i_pipe_rs_addr = 5'd7; i_tx_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b1;
    @(negedge i_clk);
    checks++; if (o_rf_rs_addr !== 5'd7) begin failures++; $display("FAIL reset_rs_addr got=%0d exp=7", o_rf_rs_addr); end
    checks++; if (o_dunit_clk_en !== 1'b1) begin failures++; $display("FAIL reset_clk_en got=%b exp=1", o_dunit_clk_en); end
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", o_busy, o_done); end
    checks++; if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx got=%b/%h exp=0/00", o_tx_valid, o_tx_data); end
  endtask

  task automatic test_full_dump();
    bit ok;
    int mism;
    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    rf[1] = 32'hDEADBEEF; rf[31] = 32'h01234567;
    build_expected();
    clear_stats();
    start_dump();
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=no_done exp=done"); end
    checks++; if (log_q.size() != 128) begin failures++; $display("FAIL full_count got=%0d exp=128", log_q.size()); end
    if (log_q.size() == 128) begin
      checks++; if ({log_q[4], log_q[5], log_q[6], log_q[7]} !== 32'hDEADBEEF) begin failures++;
        $display("FAIL full_reg1 got=%h%h%h%h exp=deadbeef", log_q[4], log_q[5], log_q[6], log_q[7]); end
      checks++; if ({log_q[124], log_q[125], log_q[126], log_q[127]} !== 32'h01234567) begin failures++;
        $display("FAIL full_reg31 got=%h%h%h%h exp=01234567", log_q[124], log_q[125], log_q[126], log_q[127]); end
      mism = 0;
      for (int i = 0; i < 128; i++) if (log_q[i] !== exp_q[i]) mism++;
      checks++; if (mism != 0) begin failures++; $display("FAIL full_stream got=%0d_bad exp=0_bad", mism); end
    end
    checks++; if (busy_cnt != 162) begin failures++; $display("FAIL full_busy_cycles got=%0d exp=162", busy_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (clk_viol != 0) begin failures++; $display("FAIL full_clk_en got=%0d_viol exp=0", clk_viol); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int hold_bad;
    int mism;
    build_expected();
    clear_stats();
    start_dump();
    for (int i = 0; i < 50; i++) begin
      @(posedge i_clk); #1;
      if (log_q.size() == 5 && o_tx_valid) break;
    end
    checks++; if (o_tx_data !== 8'hAD || !o_tx_valid) begin failures++; $display("FAIL bp_present got=%b/%h exp=1/ad", o_tx_valid, o_tx_data); end
    i_tx_ready = 1'b0;
    hold_bad = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (!(o_tx_valid === 1'b1 && o_tx_data === 8'hAD)) hold_bad++;
    end
    @(posedge i_clk); #1 i_tx_ready = 1'b1;
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL bp_hold got=%0d_bad exp=0_bad", hold_bad); end
    wait_done(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    mism = (log_q.size() == 128) ? 0 : 1;
    if (mism == 0) for (int i = 0; i < 128; i++) if (log_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0) begin failures++; $display("FAIL bp_stream got=%0d_bad size=%0d exp=0_bad size=128", mism, log_q.size()); end
    checks++; if (busy_cnt != 172) begin failures++; $display("FAIL bp_busy_cycles got=%0d exp=172", busy_cnt); end
  endtask

  task automatic test_ignore_req();
    bit ok;
    int mism;
    build_expected();
    clear_stats();
    start_dump();
    for (int i = 0; i < 100; i++) begin
      @(posedge i_clk); #1;
      if (log_q.size() == 13 && o_tx_valid) break;
    end
    i_dump_req = 1'b1;
    @(posedge i_clk); #1 i_dump_req = 1'b0;
    wait_done(400, ok);
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL ign_done got=%0d exp=1", done_cnt); end
    mism = (log_q.size() == 128) ? 0 : 1;
    if (mism == 0) for (int i = 0; i < 128; i++) if (log_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0) begin failures++; $display("FAIL ign_stream got=%0d_bad size=%0d exp=0_bad size=128", mism, log_q.size()); end
    checks++; if (busy_cnt != 162 || o_busy !== 1'b0) begin failures++; $display("FAIL ign_busy got=%0d/%b exp=162/0", busy_cnt, o_busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int mism;
    build_expected();
    clear_stats();
    start_dump();
    for (int i = 0; i < 300; i++) begin
      @(posedge i_clk); #1;
      if (log_q.size() == 41 && o_tx_valid) break;
    end
    #1 i_reset = 1'b0;
    #1;
    checks++; if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_dunit_clk_en !== 1'b1) begin failures++;
      $display("FAIL rst_mid_outputs got=v%b b%b ce%b exp=v0 b0 ce1", o_tx_valid, o_busy, o_dunit_clk_en); end
    checks++; if (o_rf_rs_addr !== 5'd7) begin failures++; $display("FAIL rst_mid_rs_addr got=%0d exp=7", o_rf_rs_addr); end
    @(posedge i_clk); #1 i_reset = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    checks++; if (done_cnt != 0 || o_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%0d/%b exp=0/0", done_cnt, o_busy); end
    clear_stats();
    start_dump();
    wait_done(400, ok);
    mism = (ok && log_q.size() == 128) ? 0 : 1;
    if (mism == 0) for (int i = 0; i < 128; i++) if (log_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0) begin failures++; $display("FAIL rst_mid_redump got=%0d_bad size=%0d exp=0_bad size=128", mism, log_q.size()); end
  endtask

  task automatic test_wb_write();
    bit ok;
    clear_stats();
    @(posedge i_clk); #1 rf[2] = 32'h55AA55AA;
    start_dump();
    wait_done(400, ok);
    checks++; if (!ok || log_q.size() != 128) begin failures++; $display("FAIL wb_count got=%0d exp=128", log_q.size()); end
    else begin
      checks++; if ({log_q[8], log_q[9], log_q[10], log_q[11]} !== 32'h55AA55AA) begin failures++;
        $display("FAIL wb_reg2 got=%h%h%h%h exp=55aa55aa", log_q[8], log_q[9], log_q[10], log_q[11]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_stats();
    @(posedge i_clk); #1 i_dump_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge i_clk);
      if (o_done) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL b2b_first got=no_done exp=done"); end
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b0 || o_dunit_clk_en !== 1'b1) begin failures++; $display("FAIL b2b_idle got=b%b ce%b exp=b0 ce1", o_busy, o_dunit_clk_en); end
    @(posedge i_clk); #1 i_dump_req = 1'b0;
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b exp=1", o_busy); end
    wait_done(400, ok);
    checks++; if (!ok || done_cnt != 2 || log_q.size() != 256) begin failures++;
      $display("FAIL b2b_second got=done%0d bytes%0d exp=done2 bytes256", done_cnt, log_q.size()); end
  endtask

  initial begin
    checks = 0; failures = 0;
    busy_cnt = 0; done_cnt = 0; clk_viol = 0;
    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_ignore_req();
    test_reset_mid();
    test_wb_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
